// File: rtl/sata_device_link_rx.sv
// Device-side SATA link receiver: answers host frames with R_RDY/R_IP/HOLD/R_OK/R_ERR.
// Optional CRC checking enabled by defining SATA_DEV_CRC_CHECK_EN.
module sata_device_link_rx #(
   parameter int          MAX_DWORDS = 2049,
   parameter logic [31:0] CRC_INIT   = 32'h52325032
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        phy_rdy,
   input  logic [31:0] rx_data,
   input  logic        rx_charisk,
   output logic [31:0] tx_data,
   output logic        tx_charisk,
   input  logic        fifo_afull,
   output logic [31:0] fis_data,
   output logic        fis_valid,
   output logic        fis_sof,
   output logic        frame_done,
   output logic        frame_good,
   output logic        frame_abort,
   output logic        busy
);
   localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
   localparam logic [31:0] P_X_RDY = 32'h5757B57C;
   localparam logic [31:0] P_R_RDY = 32'h4A4A957C;
   localparam logic [31:0] P_SOF   = 32'h3737B57C;
   localparam logic [31:0] P_EOF   = 32'hD5D5B57C;
   localparam logic [31:0] P_R_IP  = 32'h5555B57C;
   localparam logic [31:0] P_R_OK  = 32'h3535B57C;
   localparam logic [31:0] P_R_ERR = 32'h5656B57C;
   localparam logic [31:0] P_WTRM  = 32'h5858B57C;
   localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
   localparam logic [31:0] P_CONT  = 32'h9999AA7C;
   localparam logic [31:0] P_ALIGN = 32'h7B4A4ABC;
   localparam int CW = $clog2(MAX_DWORDS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RDY, S_DATA, S_EOFCHK, S_WAITWT, S_RESP
   } state_t;

   state_t      state, next;
   logic [31:0] last_prim, prim, tx_next;
   logic        cont_mode, is_align, is_cont, prim_v, data_v;
   logic        abort, sof_start, push, good_now, good_r;
   logic [31:0] held;
   logic        held_v, overflow, sof_pend;
   logic [CW-1:0] count;

   assign tx_charisk = 1'b1;
   assign busy       = (state != S_IDLE);
   assign frame_done = (state == S_EOFCHK);
   assign frame_good = frame_done && good_now;

   // classify the incoming dword: ALIGN dropped, CONT repeats last primitive
   always_comb begin
      is_align = rx_charisk && (rx_data == P_ALIGN);
      is_cont  = rx_charisk && (rx_data == P_CONT);
      prim_v   = !is_align && (rx_charisk || cont_mode);
      prim     = (rx_charisk && !is_cont) ? rx_data : last_prim;
      data_v   = !rx_charisk && !cont_mode;
   end

   // remember the last real primitive and whether CONT suppression is active
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_prim <= P_SYNC;
         cont_mode <= 1'b0;
      end else if (!phy_rdy) begin
         cont_mode <= 1'b0;
      end else if (rx_charisk && !is_align) begin
         if (is_cont) begin
            cont_mode <= 1'b1;
         end else begin
            cont_mode <= 1'b0;
            last_prim <= rx_data;
         end
      end
   end

   // state register plus registered primitive/abort outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         tx_data     <= P_SYNC;
         frame_abort <= 1'b0;
      end else begin
         state       <= next;
         tx_data     <= tx_next;
         frame_abort <= abort;
      end
   end

   // next-state decode and the primitive that the entered state sends
   always_comb begin
      next    = state;
      abort   = 1'b0;
      tx_next = P_SYNC;
      if (!phy_rdy) begin
         next  = S_IDLE;
         abort = (state == S_DATA) || (state == S_EOFCHK) ||
                 (state == S_WAITWT);
      end else begin
         case (state)
            S_IDLE:
               if (prim_v && prim == P_X_RDY) next = S_RDY;
            S_RDY:
               if (prim_v && prim == P_SOF) next = S_DATA;
               else if (prim_v && prim == P_SYNC) next = S_IDLE;
            S_DATA:
               if (prim_v && prim == P_EOF) next = S_EOFCHK;
               else if (prim_v && prim == P_SYNC) begin
                  next  = S_IDLE;
                  abort = 1'b1;
               end
            S_EOFCHK: next = S_WAITWT;
            S_WAITWT:
               if (prim_v && prim == P_WTRM) next = S_RESP;
            S_RESP:
               if (prim_v && prim == P_SYNC) next = S_IDLE;
            default: next = S_IDLE;
         endcase
      end
      case (next)
         S_RDY:    tx_next = P_R_RDY;
         S_DATA:   tx_next = fifo_afull ? P_HOLD : P_R_IP;
         S_EOFCHK: tx_next = P_R_IP;
         S_WAITWT: tx_next = P_R_IP;
         S_RESP:   tx_next = good_r ? P_R_OK : P_R_ERR;
         default:  tx_next = P_SYNC;
      endcase
   end

   assign sof_start = phy_rdy && (state == S_RDY) && prim_v &&
                      (prim == P_SOF);
   assign push      = phy_rdy && (state == S_DATA) && data_v;

`ifdef SATA_DEV_CRC_CHECK_EN
   logic [31:0] crc;

   function automatic logic [31:0] crc_step(input logic [31:0] c,
                                            input logic [31:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 31; i >= 0; i--) begin
         if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
         else              r = {r[30:0], 1'b0};
      end
      return r;
   endfunction

   // running CRC over every emitted payload dword
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         crc <= CRC_INIT;
      else if (sof_start)
         crc <= CRC_INIT;
      else if (push && held_v && count != CW'(MAX_DWORDS))
         crc <= crc_step(crc, held);
   end

   assign good_now = held_v && !overflow && (held == crc);
`else
   logic [31:0] crc_init_unused;
   assign crc_init_unused = CRC_INIT;
   assign good_now = held_v && !overflow;
`endif

   // one-dword holding pipeline that hides the trailing CRC dword
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held      <= '0;
         held_v    <= 1'b0;
         overflow  <= 1'b0;
         sof_pend  <= 1'b0;
         count     <= '0;
         good_r    <= 1'b0;
         fis_data  <= '0;
         fis_valid <= 1'b0;
         fis_sof   <= 1'b0;
      end else begin
         fis_valid <= 1'b0;
         fis_sof   <= 1'b0;
         if (sof_start) begin
            held_v   <= 1'b0;
            overflow <= 1'b0;
            sof_pend <= 1'b1;
            count    <= '0;
         end else if (push) begin
            if (held_v) begin
               if (count == CW'(MAX_DWORDS)) begin
                  overflow <= 1'b1;
               end else begin
                  fis_valid <= 1'b1;
                  fis_data  <= held;
                  fis_sof   <= sof_pend;
                  sof_pend  <= 1'b0;
                  count     <= count + CW'(1);
               end
            end
            held   <= rx_data;
            held_v <= 1'b1;
         end
         if (state == S_EOFCHK) good_r <= good_now;
      end
   end
endmodule

// File: tb/tb_sata_device_link_rx.sv
// Directed bench for sata_device_link_rx (default and MAX_DWORDS=4 instances).
// Expectations follow SATA_DEV_CRC_CHECK_EN when it is defined.
module tb_sata_device_link_rx;
   localparam logic [31:0] SYNC  = 32'hB5B5957C;
   localparam logic [31:0] X_RDY = 32'h5757B57C;
   localparam logic [31:0] R_RDY = 32'h4A4A957C;
   localparam logic [31:0] SOF   = 32'h3737B57C;
   localparam logic [31:0] EOF   = 32'hD5D5B57C;
   localparam logic [31:0] R_IP  = 32'h5555B57C;
   localparam logic [31:0] R_OK  = 32'h3535B57C;
   localparam logic [31:0] R_ERR = 32'h5656B57C;
   localparam logic [31:0] WTRM  = 32'h5858B57C;
   localparam logic [31:0] HOLD  = 32'hD5D5AA7C;
   localparam logic [31:0] HOLDA = 32'h9595AA7C;
   localparam logic [31:0] CONT  = 32'h9999AA7C;
   localparam logic [31:0] ALIGN = 32'h7B4A4ABC;

   logic clk = 0, rst_n = 0, phy_rdy = 1, fifo_afull = 0;
   logic rx_charisk = 1;
   logic [31:0] rx_data = SYNC;

   logic [31:0] tx_data, fis_data, tx_data4, fis_data4;
   logic tx_charisk, fis_valid, fis_sof, frame_done, frame_good;
   logic frame_abort, busy;
   logic tx_charisk4, fis_valid4, fis_sof4, frame_done4, frame_good4;
   logic frame_abort4, busy4;

   sata_device_link_rx dut (
      .clk(clk), .rst_n(rst_n), .phy_rdy(phy_rdy),
      .rx_data(rx_data), .rx_charisk(rx_charisk),
      .tx_data(tx_data), .tx_charisk(tx_charisk),
      .fifo_afull(fifo_afull), .fis_data(fis_data),
      .fis_valid(fis_valid), .fis_sof(fis_sof),
      .frame_done(frame_done), .frame_good(frame_good),
      .frame_abort(frame_abort), .busy(busy));

   sata_device_link_rx #(.MAX_DWORDS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .phy_rdy(phy_rdy),
      .rx_data(rx_data), .rx_charisk(rx_charisk),
      .tx_data(tx_data4), .tx_charisk(tx_charisk4),
      .fifo_afull(fifo_afull), .fis_data(fis_data4),
      .fis_valid(fis_valid4), .fis_sof(fis_sof4),
      .frame_done(frame_done4), .frame_good(frame_good4),
      .frame_abort(frame_abort4), .busy(busy4));

   always #5 clk = ~clk;

`ifdef SATA_DEV_CRC_CHECK_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   int tests = 0, fails = 0;
   logic [31:0] fq[$], sofq[$], txq[$], fq4[$];
   int done_n, good_n, abort_n, hold_n;
   int done4, good4, abort4, ok4, err4;
   logic [31:0] tx_prev = SYNC;

   always @(negedge clk) begin
      if (fis_valid) fq.push_back(fis_data);
      if (fis_valid && fis_sof) sofq.push_back(fis_data);
      if (frame_done) done_n++;
      if (frame_done && frame_good) good_n++;
      if (frame_abort) abort_n++;
      if (tx_data == HOLD) hold_n++;
      if (tx_data != tx_prev) begin
         txq.push_back(tx_data);
         tx_prev = tx_data;
      end
   end

   always @(negedge clk) begin
      if (fis_valid4) fq4.push_back(fis_data4);
      if (frame_done4) done4++;
      if (frame_done4 && frame_good4) good4++;
      if (frame_abort4) abort4++;
      if (tx_data4 == R_OK) ok4++;
      if (tx_data4 == R_ERR) err4++;
   end

   function automatic logic [31:0] crc_of(input logic [31:0] p[$]);
      logic [31:0] c = 32'h52325032;
      foreach (p[j])
         for (int i = 31; i >= 0; i--) begin
            logic fb = c[31] ^ p[j][i];
            c = c << 1;
            if (fb) c = c ^ 32'h04C11DB7;
         end
      return c;
   endfunction

   task automatic send(input logic [31:0] d, input logic k);
      @(posedge clk);
      #1;
      rx_data = d;
      rx_charisk = k;
   endtask

   task automatic clear_mon();
      fq.delete(); sofq.delete(); txq.delete(); fq4.delete();
      done_n = 0; good_n = 0; abort_n = 0; hold_n = 0;
      done4 = 0; good4 = 0; abort4 = 0; ok4 = 0; err4 = 0;
   endtask

   task automatic send_frame(input logic [31:0] p[$],
                             input logic [31:0] crc_x);
      repeat (4) send(X_RDY, 1);
      send(SOF, 1);
      foreach (p[i]) send(p[i], 0);
      send(crc_of(p) ^ crc_x, 0);
      send(EOF, 1);
      repeat (3) send(WTRM, 1);
      repeat (4) send(SYNC, 1);
   endtask

   task automatic test_reset();
      #12;
      tests++;
      if (tx_data !== SYNC || tx_charisk !== 1'b1) begin
         fails++;
         $display("FAIL reset_tx: got %h/%b want %h/1", tx_data, tx_charisk, SYNC);
      end
      tests++;
      if ({fis_valid, fis_sof, frame_done, frame_good, frame_abort, busy} !== 6'b0) begin
         fails++;
         $display("FAIL reset_flags: got %b want 000000",
                  {fis_valid, fis_sof, frame_done, frame_good, frame_abort, busy});
      end
      @(posedge clk);
      #1 rst_n = 1;
      repeat (3) send(SYNC, 1);
      clear_mon();
   endtask

   task automatic test_clean();
      logic [31:0] p[$] = '{32'h00EC8027, 32'hA0000000, 0, 0, 32'h08000000};
      logic [31:0] et[$] = '{R_RDY, R_IP, R_OK, SYNC};
      int bad = 0;
      clear_mon();
      send_frame(p, 0);
      tests++;
      if (fq.size() != 5) begin
         fails++;
         $display("FAIL clean_count: got %0d want 5", fq.size());
      end else begin
         foreach (p[i]) if (fq[i] !== p[i]) bad++;
         tests++;
         if (bad != 0) begin
            fails++;
            $display("FAIL clean_data: %0d wrong dwords, want 0", bad);
         end
      end
      tests++;
      if (sofq.size() != 1 || sofq[0] !== 32'h00EC8027) begin
         fails++;
         $display("FAIL clean_sof: got %0d sof strobes want 1 on 00ec8027", sofq.size());
      end
      tests++;
      if (done_n != 1 || good_n != 1) begin
         fails++;
         $display("FAIL clean_done: got done %0d good %0d want 1 1", done_n, good_n);
      end
      bad = (txq.size() != 4) ? 1 : 0;
      if (bad == 0) foreach (et[i]) if (txq[i] !== et[i]) bad++;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL clean_tx_seq: got %0d changes (%p) want R_RDY,R_IP,R_OK,SYNC",
                  txq.size(), txq);
      end
   endtask

   task automatic test_bad_crc();
      logic [31:0] p[$] = '{32'h00EC8027, 32'hA0000000, 0, 0, 32'h08000000};
      logic [31:0] want_resp = CRC_ON ? R_ERR : R_OK;
      int want_good = CRC_ON ? 0 : 1;
      int seen = 0;
      clear_mon();
      send_frame(p, 32'h1);
      foreach (txq[i]) if (txq[i] === want_resp) seen++;
      tests++;
      if (seen != 1) begin
         fails++;
         $display("FAIL badcrc_resp: got %0d of %h want 1", seen, want_resp);
      end
      tests++;
      if (done_n != 1 || good_n != want_good) begin
         fails++;
         $display("FAIL badcrc_good: got done %0d good %0d want 1 %0d",
                  done_n, good_n, want_good);
      end
      tests++;
      if (fq.size() != 5) begin
         fails++;
         $display("FAIL badcrc_count: got %0d want 5", fq.size());
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] p[$] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                            32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
      int bad = 0;
      clear_mon();
      repeat (2) send(X_RDY, 1);
      send(SOF, 1);
      for (int i = 0; i < 3; i++) send(p[i], 0);
      send(p[3], 0);
      fifo_afull = 1;
      send(p[4], 0);
      send(HOLDA, 1);
      send(CONT, 1);
      for (int i = 0; i < 6; i++) send(32'hBAD00000 + i, 0);
      send(HOLDA, 1);
      fifo_afull = 0;
      for (int i = 5; i < 8; i++) send(p[i], 0);
      send(crc_of(p), 0);
      send(EOF, 1);
      repeat (3) send(WTRM, 1);
      repeat (4) send(SYNC, 1);
      tests++;
      if (hold_n != 10) begin
         fails++;
         $display("FAIL bp_hold_cycles: got %0d want 10", hold_n);
      end
      if (fq.size() != 8) bad = 99;
      else foreach (p[i]) if (fq[i] !== p[i]) bad++;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL bp_data: got %0d dwords (%0d bad) want 8 exact", fq.size(), bad);
      end
      tests++;
      if (done_n != 1 || good_n != 1) begin
         fails++;
         $display("FAIL bp_good: got done %0d good %0d want 1 1", done_n, good_n);
      end
   endtask

   task automatic test_align();
      logic [31:0] p[$] = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003,
                            32'hCAFE0004, 32'hCAFE0005};
      int bad = 0;
      clear_mon();
      repeat (2) send(X_RDY, 1);
      send(SOF, 1);
      send(p[0], 0);
      send(p[1], 0);
      send(ALIGN, 1);
      send(ALIGN, 1);
      for (int i = 2; i < 5; i++) send(p[i], 0);
      send(crc_of(p), 0);
      send(EOF, 1);
      repeat (2) send(WTRM, 1);
      repeat (3) send(SYNC, 1);
      if (fq.size() != 5) bad = 99;
      else foreach (p[i]) if (fq[i] !== p[i]) bad++;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL align_data: got %0d dwords (%0d bad) want 5 exact", fq.size(), bad);
      end
      tests++;
      if (good_n != 1 || sofq.size() != 1) begin
         fails++;
         $display("FAIL align_good: got good %0d sof %0d want 1 1", good_n, sofq.size());
      end
   endtask

   task automatic test_host_abort();
      clear_mon();
      repeat (2) send(X_RDY, 1);
      send(SOF, 1);
      send(32'hA1, 0);
      send(32'hA2, 0);
      send(32'hA3, 0);
      repeat (4) send(SYNC, 1);
      tests++;
      if (abort_n != 1 || done_n != 0) begin
         fails++;
         $display("FAIL abort_pulse: got abort %0d done %0d want 1 0", abort_n, done_n);
      end
      tests++;
      if (busy !== 1'b0 || tx_data !== SYNC || fq.size() != 2) begin
         fails++;
         $display("FAIL abort_idle: got busy %b tx %h out %0d want 0 %h 2",
                  busy, tx_data, fq.size(), SYNC);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] p[$] = '{32'hF1, 32'hF2, 32'hF3, 32'hF4, 32'hF5, 32'hF6};
      int bad = 0;
      clear_mon();
      send_frame(p, 0);
      if (fq4.size() != 4) bad = 99;
      else for (int i = 0; i < 4; i++) if (fq4[i] !== p[i]) bad++;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL ovf_data: got %0d dwords (%0d bad) want 4", fq4.size(), bad);
      end
      tests++;
      if (err4 == 0 || ok4 != 0 || done4 != 1 || good4 != 0) begin
         fails++;
         $display("FAIL ovf_resp: got err %0d ok %0d done %0d good %0d want >0 0 1 0",
                  err4, ok4, done4, good4);
      end
      tests++;
      if (fq.size() != 6 || good_n != 1) begin
         fails++;
         $display("FAIL ovf_wide: got %0d dwords good %0d want 6 1", fq.size(), good_n);
      end
   endtask

   task automatic test_phy_drop();
      clear_mon();
      repeat (2) send(X_RDY, 1);
      send(SOF, 1);
      send(32'hB1, 0);
      send(32'hB2, 0);
      phy_rdy = 0;
      repeat (2) send(SYNC, 1);
      phy_rdy = 1;
      repeat (3) send(SYNC, 1);
      tests++;
      if (abort_n != 1 || abort4 != 1 || done_n != 0) begin
         fails++;
         $display("FAIL phy_abort: got %0d/%0d done %0d want 1/1 0",
                  abort_n, abort4, done_n);
      end
      tests++;
      if (busy !== 1'b0 || tx_data !== SYNC) begin
         fails++;
         $display("FAIL phy_idle: got busy %b tx %h want 0 %h", busy, tx_data, SYNC);
      end
   endtask

   task automatic test_async_reset();
      clear_mon();
      repeat (2) send(X_RDY, 1);
      send(SOF, 1);
      send(32'hC1, 0);
      send(32'hC2, 0);
      #2 rst_n = 0;
      #1;
      tests++;
      if (busy !== 1'b0 || busy4 !== 1'b0 || tx_data !== SYNC || fis_valid !== 1'b0) begin
         fails++;
         $display("FAIL arst_clear: got busy %b/%b tx %h valid %b want 0/0 %h 0",
                  busy, busy4, tx_data, fis_valid, SYNC);
      end
      rx_data = SYNC;
      rx_charisk = 1;
      @(posedge clk);
      #1 rst_n = 1;
      repeat (3) send(SYNC, 1);
      tests++;
      if (abort_n != 0 || done_n != 0) begin
         fails++;
         $display("FAIL arst_pulses: got abort %0d done %0d want 0 0", abort_n, done_n);
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_clean();
      test_bad_crc();
      test_backpressure();
      test_align();
      test_host_abort();
      test_overflow();
      test_phy_drop();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
